bask_frame_sequencer: RTL and testbench
=======================================

Name: bask_frame_sequencer

Overview:
- Feeds byte-serial data to the BASK PWM modulator and controls its `Allow` gate.
- Buffers upstream bytes in a small FIFO. On `start`, emits one frame: a preamble byte, then `FRAME_LEN` payload bytes.
- Each byte is held on `sampler` while `Allow` is high for `BYTE_TICKS` cycles. Consecutive bytes are separated by an `Allow`-low gap of `GAP_TICKS` cycles.
- Runs on the modulator's 100 kHz clock domain.

Parameters:
- BYTE_TICKS, 500, cycles `Allow` stays high per byte (≥2)
- GAP_TICKS, 16, cycles `Allow` stays low between bytes (≥1)
- FRAME_LEN, 4, payload bytes per frame (1..255)
- PREAMBLE, 8'hAA, first byte of every frame
- FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)

Ports:
- clk100khz  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous active-low reset
- din  in  8  payload byte from upstream
- din_valid  in  1  din holds a byte
- din_ready  out  1  FIFO can accept; a transfer occurs when din_valid & din_ready at a clock edge
- start  in  1  single-cycle frame request
- sampler  out  8  byte to modulator
- Allow  out  1  modulator enable
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame end
- underrun  out  1  sticky: a payload slot found the FIFO empty

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, FIFO flushed (count 0), sampler=0, Allow=0, busy=0, frame_done=0, underrun=0. Reset mid-frame aborts immediately; no frame_done is issued.
- din_ready = (count < FIFO_DEPTH). It is registered from count and does not anticipate a same-cycle pop.
- A simultaneous push and pop leaves count unchanged. Data order is strictly FIFO.
- States: IDLE, LOAD, PRE, GAP, DATA.
- IDLE:
  - Allow=0, busy=0; sampler holds its last value.
  - start=1 → LOAD, and underrun is cleared.
  - start is accepted even when the FIFO is empty.
- LOAD (1 cycle): sampler=PREAMBLE, Allow=0, busy=1 → PRE.
- PRE and DATA:
  - Allow=1 for exactly BYTE_TICKS cycles (tick counter 0..BYTE_TICKS-1).
  - Leaving DATA when payload_cnt == FRAME_LEN → IDLE, with frame_done=1 in the first IDLE cycle.
  - Otherwise → GAP.
- GAP:
  - Allow=0 for exactly GAP_TICKS cycles.
  - On entry, pop the FIFO into sampler. If the FIFO is empty, sampler=8'h00 and underrun is set.
  - payload_cnt increments; at exit → DATA.
- sampler changes only while Allow=0, and at least 1 cycle before Allow rises, so the modulator can latch on posedge Allow.
- An underrun never shortens or aborts a frame: exactly FRAME_LEN payload slots are always sent.
- start while busy is ignored. start in the same cycle as frame_done (IDLE) is accepted.
- Cycle count from the start-accepting edge to frame_done: 1 + BYTE_TICKS + FRAME_LEN·(GAP_TICKS + BYTE_TICKS). With defaults this is 2565.
- Counter widths: tick counter $clog2(max(BYTE_TICKS, GAP_TICKS)) bits; payload_cnt 8 bits.
- All outputs are registered.

Test Plan (BYTE_TICKS=4, GAP_TICKS=2, FRAME_LEN=4 unless noted):
- Reset check: assert rst=0 mid-simulation → sampler=0, Allow=0, busy=0, underrun=0, din_ready=1 immediately, without waiting for a clock edge.
- Nominal frame: push 0x11,0x22,0x33,0x44, then pulse start.
  - sampler sequence is AA,11,22,33,44.
  - Allow high 4 cycles per byte, low 2 cycles between bytes.
  - frame_done pulses 29 cycles after the start edge; busy drops in the same cycle.
- Underrun: push 0x55,0x66, then start.
  - sampler sequence is AA,55,66,00,00.
  - underrun rises at the third GAP entry and stays 1 after the frame.
  - Pulsing start again clears it.
- FIFO backpressure: hold din_valid with 0x01..0x05 before start.
  - din_ready goes low after 4 accepts.
  - 0x05 is accepted the cycle after the first pop.
  - Frame bytes are AA,01,02,03,04; 0x05 remains queued.
- start during busy: pulse start mid-DATA → no effect on sequence or timing. A start coincident with frame_done launches a new frame (LOAD next cycle).
- Reset mid-frame: rst=0 during the second DATA byte → Allow drops asynchronously, FIFO count becomes 0, and no frame_done pulse occurs.

Source files
------------

// File: rtl/bask_frame_sequencer.sv
// bask_frame_sequencer: buffers upstream bytes and plays them to the BASK modulator
// as preamble + payload frames, gating Allow high per byte with low gaps between.
module bask_frame_sequencer #(
   parameter int          BYTE_TICKS = 500,
   parameter int          GAP_TICKS  = 16,
   parameter int          FRAME_LEN  = 4,
   parameter logic [7:0]  PREAMBLE   = 8'hAA,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic       clk100khz,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       start,
   output logic [7:0] sampler,
   output logic       Allow,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);
   localparam int TW = $clog2(BYTE_TICKS > GAP_TICKS ? BYTE_TICKS : GAP_TICKS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {IDLE, LOAD, PRE, GAP, DATA} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [7:0]      pcnt_q, pcnt_d, sampler_q, sampler_d;
   logic            allow_q, busy_q, done_q, underrun_q, underrun_d, ready_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop, byte_end, gap_end, enter_gap;

   assign push      = din_valid & ready_q;
   assign byte_end  = tick_q == TW'(BYTE_TICKS - 1);
   assign gap_end   = tick_q == TW'(GAP_TICKS - 1);
   assign enter_gap = byte_end & ((state_q == PRE) | ((state_q == DATA) & (pcnt_q != 8'(FRAME_LEN))));
   // An empty FIFO at a gap entry sends a zero byte instead of stalling the frame.
   assign pop       = enter_gap & (count_q != '0);
   assign count_d   = count_q + CW'(push) - CW'(pop);

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q + 1'b1;
      pcnt_d     = pcnt_q;
      sampler_d  = sampler_q;
      underrun_d = underrun_q;
      case (state_q)
         IDLE: if (start) begin
            state_d    = LOAD;
            sampler_d  = PREAMBLE;
            underrun_d = 1'b0;
            pcnt_d     = '0;
         end
         LOAD: begin
            state_d = PRE;
            tick_d  = '0;
         end
         PRE, DATA: if (byte_end) begin
            state_d = enter_gap ? GAP : IDLE;
            tick_d  = '0;
         end
         GAP: if (gap_end) begin
            state_d = DATA;
            tick_d  = '0;
         end
         default: state_d = IDLE;
      endcase
      if (enter_gap) begin
         pcnt_d     = pcnt_q + 8'd1;
         sampler_d  = pop ? mem_q[rd_q] : 8'h00;
         underrun_d = underrun_q | ~pop;
      end
   end

   always_ff @(posedge clk100khz or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         tick_q     <= '0;
         pcnt_q     <= '0;
         sampler_q  <= '0;
         allow_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         ready_q    <= 1'b1;
         wr_q       <= '0;
         rd_q       <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         pcnt_q     <= pcnt_d;
         sampler_q  <= sampler_d;
         allow_q    <= (state_d == PRE) | (state_d == DATA);
         busy_q     <= state_d != IDLE;
         done_q     <= (state_q == DATA) & (state_d == IDLE);
         underrun_q <= underrun_d;
         ready_q    <= count_d < CW'(FIFO_DEPTH);
         wr_q       <= wr_q + AW'(push);
         rd_q       <= rd_q + AW'(pop);
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk100khz) begin
      if (push) mem_q[wr_q] <= din;
   end

   assign din_ready  = ready_q;
   assign sampler    = sampler_q;
   assign Allow      = allow_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign underrun   = underrun_q;
endmodule

// File: tb/tb_bask_frame_sequencer.sv
// tb_bask_frame_sequencer: directed + random stimulus against a frame-timeline model
// that derives every output from the cycle offset since the accepted start.
module tb_bask_frame_sequencer;
   localparam int BT = 4, GT = 2, FL = 4, FD = 4;
   localparam int TOTAL = 1 + BT + FL * (GT + BT);

   logic       clk = 1'b0, rst = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0, start = 1'b0;
   logic       din_ready, Allow, busy, frame_done, underrun;
   logic [7:0] sampler;

   bask_frame_sequencer #(.BYTE_TICKS(BT), .GAP_TICKS(GT), .FRAME_LEN(FL), .PREAMBLE(8'hAA), .FIFO_DEPTH(FD)) dut (
      .clk100khz(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .start(start), .sampler(sampler), .Allow(Allow), .busy(busy), .frame_done(frame_done),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc_n = 0, start_edge = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // model: FIFO as a queue, frame outputs from the offset m_k since the start edge
   logic [7:0] mq [$];
   logic [7:0] m_sampler = 8'h00;
   bit m_allow = 0, m_busy = 0, m_done = 0, m_under = 0, m_ready = 1, m_active = 0;
   int m_k = 0;

   task automatic model_reset();
      mq.delete();
      m_sampler = 8'h00; m_allow = 0; m_busy = 0; m_done = 0; m_under = 0;
      m_ready = 1; m_active = 0; m_k = 0;
   endtask

   task automatic model_step();
      bit ready_pre, have;
      ready_pre = mq.size() < FD;
      have = mq.size() > 0;
      m_done = 0;
      if (!m_active) begin
         if (start) begin
            m_active = 1; m_k = 0; m_sampler = 8'hAA; m_under = 0;
         end
      end else begin
         m_k++;
         if (m_k == TOTAL) begin
            m_active = 0; m_done = 1;
         end else if (m_k > BT && (m_k - 1 - BT) % (GT + BT) == 0) begin
            if (have) m_sampler = mq.pop_front();
            else begin m_sampler = 8'h00; m_under = 1; end
         end
      end
      m_busy = m_active;
      m_allow = m_active && m_k >= 1 && (m_k <= BT || ((m_k - 1 - BT) % (GT + BT)) >= GT);
      if (din_valid && ready_pre) mq.push_back(din);
      m_ready = mq.size() < FD;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   logic [7:0] cap [$];
   bit prev_allow = 0;
   always @(negedge clk) begin
      if (rst) begin
         chk("sampler", sampler, m_sampler);
         chk("Allow", Allow, m_allow);
         chk("busy", busy, m_busy);
         chk("frame_done", frame_done, m_done);
         chk("underrun", underrun, m_under);
         chk("din_ready", din_ready, m_ready);
         if (Allow && !prev_allow) cap.push_back(sampler);
         prev_allow = Allow;
      end else prev_allow = 0;
   end

   task automatic step(); @(negedge clk); endtask

   task automatic push_byte(input logic [7:0] b);
      int n = 0;
      while (!din_ready && n < 50) begin step(); n++; end
      din = b; din_valid = 1; step(); din_valid = 0;
   endtask

   task automatic pulse_start();
      start = 1; start_edge = cyc_n + 1; step(); start = 0;
   endtask

   task automatic wait_done(output int lat);
      int n = 0;
      while (!frame_done && n < 100) begin step(); n++; end
      if (!frame_done) chk("done_timeout", 0, 1);
      lat = cyc_n - start_edge;
   endtask

   task automatic check_cap(input string name, input logic [7:0] e [5]);
      chk({name, "_count"}, cap.size(), 5);
      for (int i = 0; i < 5; i++) chk(name, i < cap.size() ? int'(cap[i]) : -1, e[i]);
   endtask

   task automatic reset_literals(input string name);
      chk({name, "_sampler"}, sampler, 0);
      chk({name, "_Allow"}, Allow, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_underrun"}, underrun, 0);
      chk({name, "_din_ready"}, din_ready, 1);
      chk({name, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int lat, acc, acc_edge, dn, n;
      bit r;
      logic [7:0] e [5];
      step();
      reset_literals("por");
      rst = 1;
      repeat (2) step();

      // nominal frame
      cap.delete();
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      pulse_start();
      wait_done(lat);
      chk("nom_latency", lat, 29);
      chk("nom_busy_drop", busy, 0);
      e = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};
      check_cap("nom_seq", e);
      chk("nom_underrun", underrun, 0);
      step();

      // underrun
      cap.delete();
      push_byte(8'h55); push_byte(8'h66);
      pulse_start();
      wait_done(lat);
      chk("ur_latency", lat, 29);
      e = '{8'hAA, 8'h55, 8'h66, 8'h00, 8'h00};
      check_cap("ur_seq", e);
      repeat (3) step();
      chk("ur_sticky", underrun, 1);
      pulse_start();
      chk("ur_clear", underrun, 0);
      wait_done(lat);
      step();

      // backpressure with din_valid held
      cap.delete();
      din = 8'h01; din_valid = 1; acc = 0; n = 0;
      while (acc < 4 && n < 20) begin
         r = din_ready; step(); n++;
         if (r) begin acc++; din = din + 8'h01; end
      end
      chk("bp_accepts", acc, 4);
      chk("bp_ready_low", din_ready, 0);
      pulse_start();
      acc_edge = -1; n = 0;
      while (acc_edge < 0 && n < 20) begin
         r = din_ready; step(); n++;
         if (r) acc_edge = cyc_n;
      end
      din_valid = 0;
      chk("bp_accept_edge", acc_edge - start_edge, 6);
      repeat (3) step();
      start = 1; step(); start = 0;
      wait_done(lat);
      chk("busy_start_latency", lat, 29);
      e = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
      check_cap("bp_seq", e);

      // start coincident with frame_done
      cap.delete();
      pulse_start();
      chk("coinc_busy", busy, 1);
      chk("coinc_sampler", sampler, 8'hAA);
      wait_done(lat);
      chk("coinc_latency", lat, 29);
      e = '{8'hAA, 8'h05, 8'h00, 8'h00, 8'h00};
      check_cap("coinc_seq", e);
      step();

      // reset during the second payload byte
      push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
      pulse_start();
      repeat (14) step();
      chk("pre_rst_allow", Allow, 1);
      chk("pre_rst_sampler", sampler, 8'h72);
      #2 rst = 0;
      #1 reset_literals("midrst");
      @(negedge clk) rst = 1;
      dn = 0;
      repeat (40) begin step(); if (frame_done) dn++; end
      chk("no_done_after_rst", dn, 0);
      cap.delete();
      pulse_start();
      wait_done(lat);
      e = '{8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
      check_cap("flush_seq", e);
      step();

      // random traffic
      repeat (400) begin
         din_valid = 1'($urandom_range(0, 1));
         din = 8'($urandom);
         start = $urandom_range(0, 24) == 0;
         step();
      end
      din_valid = 0; start = 0; n = 0;
      while (busy && n < 100) begin step(); n++; end
      chk("rand_idle", busy, 0);
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
